// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_fast_adder.sv
// Single-bit full adder used as the serial adder's arithmetic cell.
module full_fast_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = x ^ y;
  assign s  = p ^ ci;
  assign co = (x & y) | (ci & p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: captures a, b, cin, adds LSB-first over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned     CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             sum_bit;
  logic             carry_bit;
  logic             last;

  full_fast_adder u_fa (
    .x  (opa[0]),
    .y  (opb[0]),
    .ci (carry_q),
    .s  (sum_bit),
    .co (carry_bit)
  );

  assign last = (state == BUSY) && (cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = BUSY;
      BUSY:    if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // The A register doubles as the result shift register: each consumed LSB
  // frees the MSB slot, which receives the new sum bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa     <= '0;
      opb     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      z       <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa     <= a;
            opb     <= b;
            carry_q <= cin;
            cnt     <= '0;
          end
        end
        BUSY: begin
          opa     <= {sum_bit, opa[WIDTH-1:1]};
          opb     <= {1'b0, opb[WIDTH-1:1]};
          carry_q <= carry_bit;
          if (last) begin
            z    <= {sum_bit, opa[WIDTH-1:1]};
            cout <= carry_bit;
`ifdef SERIAL_ADDER_OVF_EN
            ovf  <= carry_q ^ carry_bit;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
